// File: rtl/fft_frame_assembler_pkg.sv
// Shared sizing helpers and sample type for the FFT input framing path.
package fft_pkg;

    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned BUFFER_N = 32;

    function automatic int unsigned frame_w(input int unsigned s, input int unsigned b);
        return s * b;
    endfunction

    // Index width never collapses to zero so degenerate sizes still elaborate.
    function automatic int unsigned idx_w(input int unsigned b);
        return (b > 1) ? $clog2(b) : 1;
    endfunction

    localparam int unsigned FRAME_W = frame_w(SAMPLE_W, BUFFER_N);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fft_frame_assembler_if.sv
// Sample-in / frame-out bundle of the frame assembler; slave is the assembler side.
interface fft_frame_assembler_if
    import fft_pkg::*;
#(
    parameter int unsigned sample_size = 32,
    parameter int unsigned buffer_size = 32
);
    logic signed [sample_size-1:0]             in_sample;
    logic                                      in_valid;
    logic                                      in_ready;
    logic                                      flush;
    logic [frame_w(sample_size, buffer_size)-1:0] frame_out;
    logic                                      frame_valid;
    logic                                      frame_ready;
    logic [idx_w(buffer_size):0]               wr_level;

    modport master (
        output in_sample, in_valid, flush, frame_ready,
        input  in_ready, frame_out, frame_valid, wr_level
    );

    modport slave (
        input  in_sample, in_valid, flush, frame_ready,
        output in_ready, frame_out, frame_valid, wr_level
    );
endinterface

// File: rtl/fft_frame_assembler.sv
// Packs buffer_size streamed samples into one flat frame, double-buffered so
// filling continues while a completed frame waits for the FFT.
module fft_frame_assembler
    import fft_pkg::*;
#(
    parameter int unsigned sample_size = 32,
    parameter int unsigned buffer_size = 32
) (
    input logic                  clk,
    input logic                  rst,
    fft_frame_assembler_if.slave bus
);
    localparam int unsigned IW   = idx_w(buffer_size);
    localparam logic [IW-1:0] LAST = IW'(buffer_size - 1);

    logic [buffer_size-1:0][sample_size-1:0]      fill;
    logic [frame_w(sample_size, buffer_size)-1:0] frame_q;
    logic [IW-1:0]                                wr_idx;
    logic                                         full;
    logic                                         frame_valid_q;

    logic out_free, xfer, in_ready, accept, consume, do_flush;

    assign out_free = ~frame_valid_q | bus.frame_ready;
    assign xfer     = full & out_free;
    assign in_ready = ~full | out_free;
    assign accept   = bus.in_valid & in_ready;
    assign consume  = frame_valid_q & bus.frame_ready;
    // An empty fill register or an already-complete frame makes flush a no-op.
    assign do_flush = bus.flush & ~full & ((wr_idx != '0) | accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            fill          <= '0;
            frame_q       <= '0;
            wr_idx        <= '0;
            full          <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            // A sample accepted in the flush cycle lands before the zero padding starts.
            for (int unsigned k = 0; k < buffer_size; k++) begin
                if (accept && IW'(k) == wr_idx)
                    fill[k] <= bus.in_sample;
                else if (do_flush && IW'(k) >= wr_idx)
                    fill[k] <= '0;
            end

            if (do_flush)
                wr_idx <= '0;
            else if (accept)
                wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + 1'b1;

            if (do_flush || (accept && wr_idx == LAST))
                full <= 1'b1;
            else if (xfer)
                full <= 1'b0;

            if (xfer) begin
                frame_q       <= fill;
                frame_valid_q <= 1'b1;
            end else if (consume) begin
                frame_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.frame_out   = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.wr_level    = full ? (IW+1)'(buffer_size) : {1'b0, wr_idx};

endmodule

// File: tb/tb_fft_frame_assembler.sv
// Directed and stall-randomised bench for fft_frame_assembler (8-bit samples, 4 per frame).
module tb_fft_frame_assembler;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_frame_assembler_if #(.sample_size(8), .buffer_size(4)) bus ();

    fft_frame_assembler #(.sample_size(8), .buffer_size(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  samples[1000];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s, input logic with_flush);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        bus.in_sample = s;
        bus.in_valid  = 1'b1;
        bus.flush     = with_flush;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            n++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    // Monitor: every consumed frame must match the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.frame_valid && bus.frame_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_frame", bus.frame_out, 32'hxxxxxxxx);
                else
                    check("frame", bus.frame_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_sample   = '0;
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.frame_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // 1: back-to-back stream with ready tied high
        check("rst_valid", {31'd0, bus.frame_valid}, 32'd0);
        check("rst_out", bus.frame_out, 32'd0);
        check("rst_level", {29'd0, bus.wr_level}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.push_back(32'h04030201);
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b0);
            check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
        end
        check("t1_valid_latency", {31'd0, bus.frame_valid}, 32'd0);
        check("t1_level_full", {29'd0, bus.wr_level}, 32'd4);
        tick();
        check("t1_valid", {31'd0, bus.frame_valid}, 32'd1);
        check("t1_out", bus.frame_out, 32'h04030201);
        tick();

        // 2: two frames formed while downstream stalls
        bus.frame_ready = 1'b0;
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("t2_in_ready_blocked", {31'd0, bus.in_ready}, 32'd0);
        tick();
        tick();
        check("t2_held_out", bus.frame_out, 32'h04030201);
        check("t2_held_valid", {31'd0, bus.frame_valid}, 32'd1);
        bus.frame_ready = 1'b1;
        tick();
        check("t2_second_out", bus.frame_out, 32'h08070605);
        check("t2_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t2_level", {29'd0, bus.wr_level}, 32'd0);
        tick();

        // 3: partial frame closed by flush, tail zero-padded
        exp_q.push_back(32'h0000FEFF);
        send(8'hFF, 1'b0);
        send(8'hFE, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t3_level_full", {29'd0, bus.wr_level}, 32'd4);
        tick();
        check("t3_out", bus.frame_out, 32'h0000FEFF);
        check("t3_valid", {31'd0, bus.frame_valid}, 32'd1);
        check("t3_level", {29'd0, bus.wr_level}, 32'd0);
        tick();

        // 4: empty flush is a no-op; flush coinciding with an accept keeps the sample
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t4_empty_level", {29'd0, bus.wr_level}, 32'd0);
        tick();
        check("t4_empty_valid", {31'd0, bus.frame_valid}, 32'd0);
        exp_q.push_back(32'h00090909);
        send(8'h09, 1'b0);
        send(8'h09, 1'b0);
        send(8'h09, 1'b1);
        tick();
        check("t4_out", bus.frame_out, 32'h00090909);
        tick();

        // 5: reset discards a held frame and a partial fill
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0);
        tick();
        check("t5_pending", {31'd0, bus.frame_valid}, 32'd1);
        for (int i = 0; i < 3; i++) send(8'h21 + 8'(i), 1'b0);
        bus.in_sample = 8'h24;
        bus.in_valid  = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("t5_valid", {31'd0, bus.frame_valid}, 32'd0);
        check("t5_out", bus.frame_out, 32'd0);
        check("t5_level", {29'd0, bus.wr_level}, 32'd0);
        check("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 6: random valid/ready stalls over 1000 samples
        for (int i = 0; i < 1000; i++) samples[i] = 8'($urandom);
        for (int f = 0; f < 250; f++)
            exp_q.push_back({samples[4*f+3], samples[4*f+2], samples[4*f+1], samples[4*f]});
        begin
            int   idx;
            int   cyc;
            logic acc;
            idx = 0;
            cyc = 0;
            while (idx < 1000 && cyc < 20000) begin
                bus.in_valid    = ($urandom_range(0, 9) < 7);
                bus.in_sample   = samples[idx];
                bus.frame_ready = ($urandom_range(0, 9) < 6);
                @(negedge clk);
                acc = bus.in_valid & bus.in_ready;
                tick();
                if (acc) idx++;
                cyc++;
            end
            bus.in_valid = 1'b0;
            check("t6_all_sent", 32'(idx), 32'd1000);
            bus.frame_ready = 1'b1;
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 200) begin
                tick();
                cyc++;
            end
            check("t6_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
